// File: rtl/lru_refill_scheduler.sv
// lru_refill_scheduler
//   Arbitrates cache-miss refills from PORT_NUM requesters onto a single memory
//   channel. For each refill it reads the LRU victim of the chosen set, issues
//   the memory request, writes the fill into the chosen way, and marks that way
//   as most recently used. Only one refill is in flight at a time.
//
// Ports
//   clk, rst        clock; rst is asynchronous and active-low
//   missReq/Index   per-port miss request and set index (port i at [i*IBW +: IBW])
//   missDone        one-cycle completion pulse per port (FILL cycle)
//   busy            scheduler not idle
//   lruIndex        set index presented to the LRU read port
//   lruVictimWay    victim way for lruIndex, valid in the same cycle
//   lruAccess/Way   LRU most-recently-used update strobe and way
//   memReq/Index    memory read request, held until memAck
//   memAck/memValid request accepted / refill data returned
//   fillWe/Index/Way write strobe, set and way for the data/tag arrays
module lru_refill_scheduler #(
  parameter  int PORT_NUM        = 2,
  parameter  int WAY_NUM         = 4,
  parameter  int INDEX_BIT_WIDTH = 6,
  localparam int WAYW            = $clog2(WAY_NUM),
  localparam int IBW             = INDEX_BIT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PORT_NUM-1:0]     missReq,
  input  logic [PORT_NUM*IBW-1:0] missIndex,
  output logic [PORT_NUM-1:0]     missDone,
  output logic                    busy,
  output logic [IBW-1:0]          lruIndex,
  input  logic [WAYW-1:0]         lruVictimWay,
  output logic                    lruAccess,
  output logic [WAYW-1:0]         lruAccessWay,
  output logic                    memReq,
  output logic [IBW-1:0]          memIndex,
  input  logic                    memAck,
  input  logic                    memValid,
  output logic                    fillWe,
  output logic [IBW-1:0]          fillIndex,
  output logic [WAYW-1:0]         fillWay
);

  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VICTIM,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_FILL
  } state_t;

  state_t          state_reg;
  logic [PW-1:0]   rr_ptr_reg;
  logic [PW-1:0]   cur_port_reg;
  logic [IBW-1:0]  cur_index_reg;
  logic [WAYW-1:0] cur_way_reg;

  logic [IBW-1:0]  miss_index_arr [PORT_NUM];
  logic            sel_valid;
  logic [PW-1:0]   sel_port;
  int              cand;
  logic            go_fill;
  logic [PW-1:0]   rr_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_port
      assign miss_index_arr[gi] = missIndex[gi*IBW +: IBW];
      // Completion is decoded from live inputs so a requester that has dropped
      // its miss by the FILL cycle is not signalled; the serviced port always is.
      assign missDone[gi] = (state_reg == S_FILL) &&
                            ((cur_port_reg == PW'(gi)) ||
                             (missReq[gi] && (miss_index_arr[gi] == cur_index_reg)));
    end
  endgenerate

  // Round-robin pick: scan from the highest offset down so the requester
  // closest to rr_ptr_reg is the last (winning) assignment.
  always_comb begin
    sel_valid = 1'b0;
    sel_port  = '0;
    cand      = 0;
    for (int k = PORT_NUM - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr_reg) + k) % PORT_NUM;
      if (missReq[cand]) begin
        sel_valid = 1'b1;
        sel_port  = PW'(cand);
      end
    end
  end

  assign go_fill = ((state_reg == S_MEM_REQ) && memAck && memValid) ||
                   ((state_reg == S_MEM_WAIT) && memValid);

  assign rr_ptr_next = (cur_port_reg == PW'(PORT_NUM - 1)) ? '0 : cur_port_reg + PW'(1);

  // Outputs are registered and loaded on the transition into the state in
  // which they must be visible, so they line up with state_reg.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      rr_ptr_reg    <= '0;
      cur_port_reg  <= '0;
      cur_index_reg <= '0;
      cur_way_reg   <= '0;
      busy          <= 1'b0;
      lruIndex      <= '0;
      lruAccess     <= 1'b0;
      lruAccessWay  <= '0;
      memReq        <= 1'b0;
      memIndex      <= '0;
      fillWe        <= 1'b0;
      fillIndex     <= '0;
      fillWay       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (sel_valid) begin
            state_reg     <= S_VICTIM;
            cur_port_reg  <= sel_port;
            cur_index_reg <= miss_index_arr[sel_port];
            lruIndex      <= miss_index_arr[sel_port];
            busy          <= 1'b1;
          end
        end
        S_VICTIM: begin
          state_reg   <= S_MEM_REQ;
          cur_way_reg <= lruVictimWay;
          lruIndex    <= '0;
          memReq      <= 1'b1;
          memIndex    <= cur_index_reg;
        end
        S_MEM_REQ: begin
          if (memAck) begin
            memReq    <= 1'b0;
            memIndex  <= '0;
            state_reg <= memValid ? S_FILL : S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (memValid) begin
            state_reg <= S_FILL;
          end
        end
        S_FILL: begin
          state_reg    <= S_IDLE;
          rr_ptr_reg   <= rr_ptr_next;
          busy         <= 1'b0;
          lruIndex     <= '0;
          lruAccess    <= 1'b0;
          lruAccessWay <= '0;
          fillWe       <= 1'b0;
          fillIndex    <= '0;
          fillWay      <= '0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase

      if (go_fill) begin
        fillWe       <= 1'b1;
        fillIndex    <= cur_index_reg;
        fillWay      <= cur_way_reg;
        lruAccess    <= 1'b1;
        lruAccessWay <= cur_way_reg;
        lruIndex     <= cur_index_reg;
      end
    end
  end

endmodule

// File: tb/tb_lru_refill_scheduler.sv
// tb_lru_refill_scheduler
//   Directed self-checking bench for lru_refill_scheduler (2 ports, 4 ways,
//   6-bit index). Inputs change 1 time unit after each rising edge and
//   outputs are sampled at that same point.
module tb_lru_refill_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  missReq = '0;
  logic [11:0] missIndex = '0;
  logic [1:0]  missDone;
  logic        busy;
  logic [5:0]  lruIndex;
  logic [1:0]  lruVictimWay = '0;
  logic        lruAccess;
  logic [1:0]  lruAccessWay;
  logic        memReq;
  logic [5:0]  memIndex;
  logic        memAck = 1'b0;
  logic        memValid = 1'b0;
  logic        fillWe;
  logic [5:0]  fillIndex;
  logic [1:0]  fillWay;

  int n_cmp = 0;
  int n_err = 0;
  int exp_port;
  int exp_idx;

  lru_refill_scheduler #(
    .PORT_NUM(2),
    .WAY_NUM(4),
    .INDEX_BIT_WIDTH(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .missReq(missReq),
    .missIndex(missIndex),
    .missDone(missDone),
    .busy(busy),
    .lruIndex(lruIndex),
    .lruVictimWay(lruVictimWay),
    .lruAccess(lruAccess),
    .lruAccessWay(lruAccessWay),
    .memReq(memReq),
    .memIndex(memIndex),
    .memAck(memAck),
    .memValid(memValid),
    .fillWe(fillWe),
    .fillIndex(fillIndex),
    .fillWay(fillWay)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idx(input int i0, input int i1);
    missIndex = {6'(i1), 6'(i0)};
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_busy",     32'(busy), 0);
    check("rst_memReq",   32'(memReq), 0);
    check("rst_fillWe",   32'(fillWe), 0);
    check("rst_lruAcc",   32'(lruAccess), 0);
    check("rst_lruIndex", 32'(lruIndex), 0);
    check("rst_missDone", 32'(missDone), 0);
    rst = 1'b1;

    // 1: single miss, port0 idx 5, victim 2, memory always ready
    missReq = 2'b01; set_idx(5, 0); lruVictimWay = 2'd2; memAck = 1'b1; memValid = 1'b1;
    tick();
    check("t1_victim_busy",  32'(busy), 1);
    check("t1_victim_idx",   32'(lruIndex), 5);
    check("t1_victim_done",  32'(missDone), 0);
    tick();
    check("t1_memReq",       32'(memReq), 1);
    check("t1_memIndex",     32'(memIndex), 5);
    check("t1_memreq_lruix", 32'(lruIndex), 0);
    tick();
    check("t1_fillWe",       32'(fillWe), 1);
    check("t1_fillIndex",    32'(fillIndex), 5);
    check("t1_fillWay",      32'(fillWay), 2);
    check("t1_lruAccess",    32'(lruAccess), 1);
    check("t1_lruAccessWay", 32'(lruAccessWay), 2);
    check("t1_fill_lruIdx",  32'(lruIndex), 5);
    check("t1_missDone",     32'(missDone), 1);
    check("t1_fill_memReq",  32'(memReq), 0);
    missReq = 2'b00;
    tick();
    check("t1_idle_busy",    32'(busy), 0);
    check("t1_idle_fillWe",  32'(fillWe), 0);
    check("t1_idle_done",    32'(missDone), 0);

    // 2: round-robin, both ports requesting continuously (fresh reset -> rrPtr 0)
    rst = 1'b0; tick(); rst = 1'b1;
    missReq = 2'b11; set_idx(3, 9); lruVictimWay = 2'd1;
    for (int r = 0; r < 4; r++) begin
      exp_port = r % 2;
      exp_idx  = (exp_port == 1) ? 9 : 3;
      tick();
      check("t2_victim_idx", 32'(lruIndex), 32'(exp_idx));
      tick();
      check("t2_mem_idx",    32'(memIndex), 32'(exp_idx));
      tick();
      check("t2_done",       32'(missDone), 32'(1 << exp_port));
      check("t2_fill_idx",   32'(fillIndex), 32'(exp_idx));
      check("t2_fill_way",   32'(fillWay), 1);
      tick();
      check("t2_idle_gap",   32'(busy), 0);
    end
    missReq = 2'b00;

    // 3: coalesce, both ports miss on idx 7 (rrPtr 0 -> port0 serviced)
    missReq = 2'b11; set_idx(7, 7); lruVictimWay = 2'd3;
    tick();
    check("t3_victim_idx", 32'(lruIndex), 7);
    tick();
    check("t3_memReq",     32'(memReq), 1);
    check("t3_memIndex",   32'(memIndex), 7);
    tick();
    check("t3_done",       32'(missDone), 3);
    check("t3_fillWay",    32'(fillWay), 3);
    check("t3_lruAccWay",  32'(lruAccessWay), 3);
    check("t3_fill_memReq",32'(memReq), 0);
    missReq = 2'b00;
    tick();
    check("t3_idle_busy",  32'(busy), 0);
    tick();
    check("t3_no_2nd_req", 32'(memReq), 0);
    check("t3_no_2nd_busy",32'(busy), 0);

    // 4: backpressure, ack after 5 stalled cycles, data 3 cycles after ack
    missReq = 2'b01; set_idx(12, 0); lruVictimWay = 2'd1; memAck = 1'b0; memValid = 1'b0;
    tick();
    check("t4_victim_busy", 32'(busy), 1);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t4_memReq_held", 32'(memReq), 1);
      check("t4_memIndex",    32'(memIndex), 12);
      check("t4_req_busy",    32'(busy), 1);
      check("t4_req_fillWe",  32'(fillWe), 0);
      if (c == 5) memAck = 1'b1;
    end
    for (int w = 0; w < 3; w++) begin
      tick();
      memAck = 1'b0;
      check("t4_wait_memReq", 32'(memReq), 0);
      check("t4_wait_busy",   32'(busy), 1);
      check("t4_wait_fillWe", 32'(fillWe), 0);
    end
    memValid = 1'b1;
    tick();
    check("t4_fillWe",    32'(fillWe), 1);
    check("t4_fillIndex", 32'(fillIndex), 12);
    check("t4_fillWay",   32'(fillWay), 1);
    check("t4_done",      32'(missDone), 1);
    memValid = 1'b0; missReq = 2'b00;
    tick();
    check("t4_post_fillWe", 32'(fillWe), 0);
    check("t4_post_busy",   32'(busy), 0);

    // 5: reset while waiting for data, then a late memValid
    missReq = 2'b10; set_idx(0, 20); lruVictimWay = 2'd2; memAck = 1'b1; memValid = 1'b0;
    tick();
    check("t5_victim_idx", 32'(lruIndex), 20);
    tick();
    check("t5_memIndex",   32'(memIndex), 20);
    tick();
    check("t5_wait_busy",  32'(busy), 1);
    rst = 1'b0; missReq = 2'b00; memAck = 1'b0;
    #1;
    check("t5_rst_busy",   32'(busy), 0);
    check("t5_rst_memReq", 32'(memReq), 0);
    check("t5_rst_fillWe", 32'(fillWe), 0);
    check("t5_rst_done",   32'(missDone), 0);
    tick();
    rst = 1'b1; memValid = 1'b1;
    for (int l = 0; l < 3; l++) begin
      tick();
      check("t5_late_busy",   32'(busy), 0);
      check("t5_late_fillWe", 32'(fillWe), 0);
      check("t5_late_done",   32'(missDone), 0);
    end
    memValid = 1'b0;

    // 6: port1 (same set, not serviced) drops its miss while waiting
    missReq = 2'b11; set_idx(33, 33); lruVictimWay = 2'd3; memAck = 1'b1; memValid = 1'b0;
    tick();
    check("t6_victim_idx", 32'(lruIndex), 33);
    tick();
    tick();
    check("t6_wait_busy",  32'(busy), 1);
    missReq = 2'b01; memValid = 1'b1;
    tick();
    check("t6_done",       32'(missDone), 1);
    check("t6_fillWe",     32'(fillWe), 1);
    check("t6_fillIndex",  32'(fillIndex), 33);
    check("t6_fillWay",    32'(fillWay), 3);
    missReq = 2'b00; memValid = 1'b0;
    tick();

    // 7: the serviced port itself drops its miss; it is still signalled
    missReq = 2'b01; set_idx(40, 0); lruVictimWay = 2'd2; memAck = 1'b1; memValid = 1'b0;
    tick();
    tick();
    tick();
    missReq = 2'b00; memValid = 1'b1;
    tick();
    check("t7_done",    32'(missDone), 1);
    check("t7_fillWay", 32'(fillWay), 2);
    memValid = 1'b0; memAck = 1'b0;
    tick();
    check("t7_idle_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
